// File: rtl/rx_serial_7o1.sv
// ---------------------------------------------------------------------------
// rx_serial_7o1
// Asynchronous serial receiver for 7O1 frames: 1 start bit, 7 data bits sent
// LSB first, 1 odd-parity bit and 1 stop bit. Every decoded character is
// handed to the control unit with a one-cycle `pronto` pulse. Frames with a
// parity or stop-bit error are still delivered; the consumer decides whether
// to discard them.
//
// Ports
//   clock           in   1  system clock, rising edge
//   reset           in   1  synchronous, active-high
//   entrada_serial  in   1  asynchronous serial line, idle high
//   dados_ascii     out  7  last received character, held until next pronto
//   pronto          out  1  one-cycle pulse: new character, flags valid
//   erro_paridade   out  1  parity of the last frame was wrong
//   erro_parada     out  1  stop bit of the last frame was sampled 0
//   ocupado         out  1  high while a frame is in progress (state != IDLE)
//   db_estado       out  4  FSM state code (IDLE 0 .. ESPERA 6)
//
// Handshake: pronto is a push-only strobe with no ready/backpressure. It is
// high for exactly one clock and dados_ascii / erro_* are valid in that
// cycle and stay unchanged until the next pronto.
// ---------------------------------------------------------------------------
module rx_serial_7o1 #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [6:0] dados_ascii,
  output logic       pronto,
  output logic       erro_paridade,
  output logic       erro_parada,
  output logic       ocupado,
  output logic [3:0] db_estado
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // Terminal counts of the bit-timing counter.
  localparam logic [TW-1:0] TICK_HALF_END = TW'(HALF_BIT - 1);
  localparam logic [TW-1:0] TICK_BIT_END  = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_START  = 4'd1,
    S_DATA   = 4'd2,
    S_PARITY = 4'd3,
    S_STOP   = 4'd4,
    S_DONE   = 4'd5,
    S_ESPERA = 4'd6
  } state_t;

  state_t        r_state;
  logic          r_rx_meta;
  logic          r_rx_s;
  logic [TW-1:0] r_tick;
  logic [2:0]    r_bit_idx;
  logic [6:0]    r_shift;
  logic          r_par_err;
  logic          r_stop_err;

  // Ones count of data plus parity must be odd; a reduction XOR of 1 means odd.
  logic w_par_err;
  assign w_par_err = ~((^r_shift) ^ r_rx_s);

  assign db_estado = r_state;
  assign ocupado   = (r_state != S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rx_meta     <= 1'b1;
      r_rx_s        <= 1'b1;
      r_tick        <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_par_err     <= 1'b0;
      r_stop_err    <= 1'b0;
      dados_ascii   <= '0;
      pronto        <= 1'b0;
      erro_paridade <= 1'b0;
      erro_parada   <= 1'b0;
    end else begin
      // Two-flop synchronizer; the FSM only ever looks at r_rx_s.
      r_rx_meta <= entrada_serial;
      r_rx_s    <= r_rx_meta;

      case (r_state)
        S_IDLE: begin
          r_tick <= '0;
          if (!r_rx_s) begin
            r_state <= S_START;
          end
        end

        S_START: begin
          if (r_tick == TICK_HALF_END) begin
            r_tick <= '0;
            // Line back high by mid-start means it was only a glitch.
            if (!r_rx_s) begin
              r_state   <= S_DATA;
              r_bit_idx <= '0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end

        S_DATA: begin
          if (r_tick == TICK_BIT_END) begin
            r_tick  <= '0;
            r_shift <= {r_rx_s, r_shift[6:1]};
            if (r_bit_idx == 3'd6) begin
              r_state <= S_PARITY;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end

        S_PARITY: begin
          if (r_tick == TICK_BIT_END) begin
            r_tick    <= '0;
            r_par_err <= w_par_err;
            r_state   <= S_STOP;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end

        S_STOP: begin
          if (r_tick == TICK_BIT_END) begin
            r_tick        <= '0;
            r_stop_err    <= ~r_rx_s;
            // Outputs are loaded here so they are valid during the DONE cycle,
            // which is the cycle pronto is high.
            pronto        <= 1'b1;
            dados_ascii   <= r_shift;
            erro_paridade <= r_par_err;
            erro_parada   <= ~r_rx_s;
            r_state       <= S_DONE;
          end else begin
            r_tick <= r_tick + 1'b1;
          end
        end

        S_DONE: begin
          pronto <= 1'b0;
          // A low stop bit usually means a break; wait for the line to
          // recover instead of treating the low level as a new start edge.
          r_state <= r_stop_err ? S_ESPERA : S_IDLE;
        end

        S_ESPERA: begin
          if (r_rx_s) begin
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_tick  <= '0;
          pronto  <= 1'b0;
        end
      endcase
    end
  end

endmodule
